// File: rtl/message_scroller_if.sv
// Control, write and window-output bundle between the message scroller and its neighbours.
// wr_en is a single-cycle strobe with no back-pressure: mem[wr_addr] takes wr_data on every edge where it is high.
interface message_scroller_if;
  logic       scroll_en;
  logic       dir;
  logic       step;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] an3char;
  logic [3:0] an2char;
  logic [3:0] an1char;
  logic [3:0] an0char;
  logic [3:0] ptr;
  logic       tick;

  modport master (
    output scroll_en, dir, step, wr_en, wr_addr, wr_data,
    input  an3char, an2char, an1char, an0char, ptr, tick
  );

  modport slave (
    input  scroll_en, dir, step, wr_en, wr_addr, wr_data,
    output an3char, an2char, an1char, an0char, ptr, tick
  );
endinterface

// File: rtl/message_scroller.sv
// 16x4 message buffer with a 4-character sliding window for the 7-seg display path.
// The window moves on a prescaled tick or on a manual step edge; every output is registered.
module message_scroller #(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input logic            clk,
  input logic            reset,
  message_scroller_if.slave bus
);

  logic [3:0]       mem_q [16];
  logic [3:0]       mem_d [16];
  logic [3:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             step_d_q, step_d_d;
  logic [3:0]       an3_q, an3_d;
  logic [3:0]       an2_q, an2_d;
  logic [3:0]       an1_q, an1_d;
  logic [3:0]       an0_q, an0_d;
  logic             step_pulse;
  logic             adv;

  assign step_pulse = bus.step & ~step_d_q;
  // Registered tick: the automatic advance lands one cycle after tick is seen.
  assign adv        = tick_q | step_pulse;

  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (bus.scroll_en) begin
      if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    step_d_d = bus.step;
    ptr_d    = ptr_q;
    if (adv) begin
      ptr_d = bus.dir ? (ptr_q - 4'd1) : (ptr_q + 4'd1);
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (bus.wr_en) begin
      mem_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Window reads the pre-edge buffer and pointer, giving one cycle of latency.
  always_comb begin
    an3_d = mem_q[ptr_q];
    an2_d = mem_q[ptr_q + 4'd1];
    an1_d = mem_q[ptr_q + 4'd2];
    an0_d = mem_q[ptr_q + 4'd3];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 4'(i);
      end
      ptr_q    <= 4'd0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      step_d_q <= 1'b0;
      an3_q    <= 4'd0;
      an2_q    <= 4'd1;
      an1_q    <= 4'd2;
      an0_q    <= 4'd3;
    end else begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= mem_d[i];
      end
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      step_d_q <= step_d_d;
      an3_q    <= an3_d;
      an2_q    <= an2_d;
      an1_q    <= an1_d;
      an0_q    <= an0_d;
    end
  end

  assign bus.an3char = an3_q;
  assign bus.an2char = an2_q;
  assign bus.an1char = an1_q;
  assign bus.an0char = an0_q;
  assign bus.ptr     = ptr_q;
  assign bus.tick    = tick_q;

endmodule

// File: tb/tb_message_scroller.sv
// Bench for message_scroller: directed scenarios plus random traffic, all checked
// cycle by cycle against a buffer/pointer reference model.
module tb_message_scroller;
  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  message_scroller_if bus();

  message_scroller #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [20:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mem [16];
  int m_win [4];
  int m_ptr;
  int m_run;
  bit m_tick;
  bit m_step_prev;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = i;
    for (int k = 0; k < 4; k++) m_win[k] = k;
    m_ptr = 0; m_run = 0; m_tick = 0; m_step_prev = 0;
  endfunction

  function automatic logic [20:0] model_vec();
    return {m_win[0][3:0], m_win[1][3:0], m_win[2][3:0], m_win[3][3:0], m_ptr[3:0], m_tick};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {bus.an3char, bus.an2char, bus.an1char, bus.an0char, bus.ptr, bus.tick};
  endfunction

  function automatic logic [15:0] win();
    return {bus.an3char, bus.an2char, bus.an1char, bus.an0char};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance model and DUT by one clock using the inputs currently driven.
  task automatic cycle();
    int  nw [4];
    bit  adv;
    for (int k = 0; k < 4; k++) nw[k] = m_mem[(m_ptr + k) % 16];
    adv = m_tick || (bus.step && !m_step_prev);
    if (adv) m_ptr = bus.dir ? (m_ptr + 15) % 16 : (m_ptr + 1) % 16;
    if (bus.scroll_en) begin
      m_run++;
      m_tick = (m_run % TICK_DIV) == 0;
    end else begin
      m_run  = 0;
      m_tick = 0;
    end
    m_step_prev = bus.step;
    if (bus.wr_en) m_mem[bus.wr_addr] = int'(bus.wr_data);
    m_win = nw;
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    check("cycle", 32'(dut_vec()), 32'(exp_q.pop_front()));
  endtask

  task automatic step_once(input logic d);
    bus.dir  = d;
    bus.step = 1'b1;
    cycle();
    bus.step = 1'b0;
    cycle();
  endtask

  task automatic write(input logic [3:0] a, input logic [3:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    cycle();
    bus.wr_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ticks;
    int gap;
    int p;
    bus.scroll_en = 0; bus.dir = 0; bus.step = 0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    model_reset();
    #2 reset = 1'b0;
    #1 check("reset_state", 32'(dut_vec()), 32'({16'h0123, 4'd0, 1'b0}));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Idle: no tick with scrolling disabled
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.tick) ticks++;
    end
    check("idle_no_tick", 32'(ticks), 32'd0);
    check("idle_window", 32'(win()), 32'h0123);

    // Automatic forward scrolling up to ptr=14 and the wrapped window
    bus.scroll_en = 1'b1;
    for (int i = 0; i < 200 && bus.ptr != 4'd14; i++) cycle();
    check("reach_ptr14", 32'(bus.ptr), 32'd14);
    cycle();
    check("window_ptr14", 32'(win()), 32'hEF01);

    // Tick period
    for (int i = 0; i < 20 && !bus.tick; i++) cycle();
    check("tick_seen", 32'(bus.tick), 32'd1);
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(); gap++;
      if (bus.tick) break;
    end
    check("tick_period", 32'(gap), 32'(TICK_DIV));

    // Wrap 15 -> 0
    for (int i = 0; i < 200 && bus.ptr != 4'd0; i++) cycle();
    check("wrap_to_0", 32'(bus.ptr), 32'd0);
    bus.scroll_en = 1'b0;
    cycle(); cycle();

    // Backward step from 0 wraps to 15
    bus.dir = 1'b1; bus.step = 1'b1;
    cycle();
    check("back_ptr15", 32'(bus.ptr), 32'd15);
    bus.step = 1'b0;
    cycle();
    check("back_window", 32'(win()), 32'hF012);

    // Held step advances exactly once
    bus.dir = 1'b0; bus.step = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    bus.step = 1'b0;
    cycle();
    check("step_hold", 32'(bus.ptr), 32'd0);

    // Step edge coinciding with tick gives a single advance
    bus.scroll_en = 1'b1;
    for (int i = 0; i < 20 && !bus.tick; i++) cycle();
    check("tick_before_step", 32'(bus.tick), 32'd1);
    p = int'(bus.ptr);
    bus.step = 1'b1;
    cycle();
    check("tick_and_step", 32'(bus.ptr), 32'((p + 1) % 16));
    bus.step = 1'b0; bus.scroll_en = 1'b0;
    cycle();

    // Runtime write inside and outside the window at ptr=0
    for (int i = 0; i < 20 && bus.ptr != 4'd0; i++) step_once(1'b0);
    check("back_to_0", 32'(bus.ptr), 32'd0);
    cycle();
    write(4'd2, 4'hA);
    cycle();
    check("write_in_window", 32'(win()), 32'h01A3);
    write(4'd9, 4'h5);
    cycle();
    check("write_outside", 32'(win()), 32'h01A3);

    // Asynchronous reset mid-scroll with ptr=7, cnt=2
    for (int i = 0; i < 7; i++) step_once(1'b0);
    check("ptr7", 32'(bus.ptr), 32'd7);
    bus.scroll_en = 1'b1;
    cycle(); cycle();
    #2 reset = 1'b0;
    #1 check("async_reset", 32'(dut_vec()), 32'({16'h0123, 4'd0, 1'b0}));
    model_reset();
    exp_q.delete();
    bus.scroll_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    cycle();
    check("mem_restored", 32'(win()), 32'h0123);
    step_once(1'b0); step_once(1'b0);
    check("mem9_restored", 32'(win()), 32'h89AB + 32'h0 - 32'h89AB + 32'h2345);
    for (int i = 0; i < 7; i++) step_once(1'b0);
    cycle();
    check("window_ptr9", 32'(win()), 32'h9ABC);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      bus.scroll_en = ($urandom_range(0, 9) < 8);
      bus.dir       = $urandom_range(0, 1);
      bus.step      = ($urandom_range(0, 3) == 0);
      bus.wr_en     = ($urandom_range(0, 3) == 0);
      bus.wr_addr   = 4'($urandom_range(0, 15));
      bus.wr_data   = 4'($urandom_range(0, 15));
      cycle();
    end

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/message_scroller.md
Name: message_scroller

Overview:
- Upstream stage of the 4-digit 7-seg display path.
- Holds a 16-entry × 4-bit message buffer and presents a 4-character window on an3char..an0char, which feed the display multiplexer.
- Advances the window automatically at a prescaled rate, or one position per manual step.
- Message contents are writable at runtime.

Parameters:
TICK_DIV, 25000000, clocks per automatic scroll step (0.5 s at 50 MHz); legal range 2..2^CNT_W.
CNT_W, 25, prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
scroll_en  input  1  1 = automatic scrolling enabled
dir  input  1  0 = window moves forward (ptr+1), 1 = backward (ptr-1)
step  input  1  manual advance request, synchronous level; acted on at its rising edge
wr_en  input  1  write strobe for message buffer
wr_addr  input  4  buffer write address
wr_data  input  4  buffer write data (character code)
an3char  output  4  window char 0 = mem[ptr], leftmost digit
an2char  output  4  mem[(ptr+1) mod 16]
an1char  output  4  mem[(ptr+2) mod 16]
an0char  output  4  mem[(ptr+3) mod 16], rightmost digit
ptr  output  4  current window start index
tick  output  1  one-cycle pulse when the prescaler expires

Behaviour:
Reset (reset=0, async):
- mem[i]=i for i=0..15.
- ptr=0, prescaler cnt=0, step_d=0, tick=0.
- an3char=0, an2char=1, an1char=2, an0char=3.
- Reset mid-operation discards any pending tick or step and restores all of the above immediately, without waiting for a clock edge.

Prescaler:
- If scroll_en=1: cnt increments each cycle. When cnt=TICK_DIV-1, cnt<=0 and tick<=1 for exactly one cycle; otherwise tick<=0.
- If scroll_en=0: cnt<=0 and tick<=0. Re-enabling restarts a full TICK_DIV period.

Step edge detect:
- step_d<=step each cycle.
- step_pulse = step & ~step_d. A held level produces exactly one advance.

Advance:
- adv = tick | step_pulse. Uses the registered tick, so an automatic advance occurs the cycle after tick is asserted.
- A tick and a step_pulse in the same cycle give a single advance, not two.
- When adv=1: ptr<=ptr+1 if dir=0, ptr<=ptr-1 if dir=1. Arithmetic is 4-bit modulo 16, so 15→0 forward and 0→15 backward.
- dir is sampled in the advance cycle only.

Write:
- When wr_en=1: mem[wr_addr]<=wr_data on that edge.
- A write and an advance in the same cycle are independent; both take effect.

Window outputs:
- Registered from the current mem and ptr each cycle, so 1-cycle latency: a ptr change or write at edge N is visible on outputs after edge N+1.
- Window index arithmetic is modulo 16; e.g. ptr=14 gives E,F,0,1 from the reset contents.
- A write to an address outside the current window does not change the outputs.
- Outputs change only at clock edges (glitch-free toward the display multiplexer).

Test Plan:
1. Reset/idle (TICK_DIV=4): release reset with scroll_en=0 → an3..an0 = 0,1,2,3; ptr=0; tick never asserts over 20 cycles.
2. Auto forward (TICK_DIV=4, scroll_en=1, dir=0) → tick pulses every 4 cycles; ptr 0→1→2; after 16 ticks ptr wraps 15→0; at ptr=14, outputs = E,F,0,1.
3. Backward wrap (dir=1, one step pulse from ptr=0) → ptr=15; outputs F,0,1,2 two cycles after the step edge.
4. Step semantics: hold step=1 for 10 cycles with scroll_en=0 → ptr advances by exactly 1. Assert a step edge in the same cycle tick is high → ptr advances by 1, not 2.
5. Runtime write: wr_en, wr_addr=2, wr_data=A at ptr=0 → an1char=A one cycle later, other outputs unchanged. Write to addr 9 while ptr=0 → outputs unchanged.
6. Async reset mid-scroll: pull reset=0 between clock edges with ptr=7 and cnt=2 → ptr=0, tick=0, outputs 0,1,2,3 immediately; previously written buffer data is restored to i.
